// File: rtl/ram_dump.sv
// ram_dump: sequential RAM reader.
//
// Reads a contiguous address range from the shared 8-bit RAM, one byte at a
// time, and streams each byte out over a valid/ready interface. The RAM read
// port has a registered q with one-cycle latency, so every byte takes three
// cycles: REQ (issue read), CAP (register q), SEND (wait for handshake).
// The address wraps FF->00. A len of 0 means 256 bytes.
//
// Optional feature: define DUMP_CHECKSUM_EN to append one checksum byte,
// the modulo-256 sum of all data bytes. That byte carries out_last, so the
// stream is len+1 bytes long. With the macro undefined, out_last marks the
// final data byte instead.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset, aborts any dump
//   start      in   begin a dump (sampled only while idle)
//   base       in   first address, latched on start
//   len        in   byte count (0 = 256), latched on start
//   busy       out  dump in progress
//   done       out  one-cycle pulse after the final handshake
//   addr       out  RAM address (holds the current address in every state)
//   rden       out  RAM read enable
//   q          in   RAM read data, valid the cycle after rden
//   out_data   out  stream byte
//   out_valid  out  stream byte valid
//   out_ready  in   sink accepts byte
//   out_last   out  final byte of the stream
module ram_dump (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] base,
    input  logic [7:0] len,
    output logic       busy,
    output logic       done,
    output logic [7:0] addr,
    output logic       rden,
    input  logic [7:0] q,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAP,
        SEND
`ifdef DUMP_CHECKSUM_EN
        , SUM
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cur_q, cur_d;
    logic [8:0] rem_q, rem_d;     // 9 bits so that a full 256-byte dump fits
    logic [7:0] data_q, data_d;
    logic       done_q, done_d;
    logic       hs;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
`endif

    assign hs = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= 8'h00;
            rem_q   <= 9'd0;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            sum_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            done_q  <= done_d;
`ifdef DUMP_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rem_d   = rem_q;
        data_d  = data_q;
        done_d  = 1'b0;
`ifdef DUMP_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_d   = base;
                    rem_d   = (len == 8'h00) ? 9'd256 : {1'b0, len};
`ifdef DUMP_CHECKSUM_EN
                    sum_d   = 8'h00;
`endif
                    state_d = REQ;
                end
            end
            REQ: begin
                state_d = CAP;
            end
            CAP: begin
                // q reflects the read issued in REQ
                data_d  = q;
                cur_d   = cur_q + 8'd1;
                rem_d   = rem_q - 9'd1;
                state_d = SEND;
            end
            SEND: begin
                if (hs) begin
`ifdef DUMP_CHECKSUM_EN
                    sum_d = sum_q + data_q;
`endif
                    if (rem_q != 9'd0) begin
                        state_d = REQ;
                    end else begin
`ifdef DUMP_CHECKSUM_EN
                        state_d = SUM;
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            SUM: begin
                if (hs) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign addr = cur_q;
    assign rden = (state_q == REQ);

`ifdef DUMP_CHECKSUM_EN
    assign out_valid = (state_q == SEND) || (state_q == SUM);
    assign out_data  = (state_q == SUM) ? sum_q : data_q;
    assign out_last  = (state_q == SUM);
`else
    assign out_valid = (state_q == SEND);
    assign out_data  = data_q;
    assign out_last  = (state_q == SEND) && (rem_q == 9'd0);
`endif

endmodule

// File: tb/tb_ram_dump.sv
module tb_ram_dump;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] base;
    logic [7:0] len;
    logic       busy;
    logic       done;
    logic [7:0] addr;
    logic       rden;
    logic [7:0] ram_q;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    ram_dump dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
        .busy(busy), .done(done), .addr(addr), .rden(rden), .q(ram_q),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    // RAM: mem[a] = a ^ 5A, registered q, updates only on a read
    initial ram_q = 8'h00;
    always @(posedge clk) if (rden) ram_q <= addr ^ 8'h5A;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at time %0t", nm, act, exp, $time);
        end
    endtask

    // ready driver: 0 = always 1, 1 = random, 2 = pattern 0,0,1
    int rmode = 0;
    int pc    = 0;
    initial out_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
                out_ready = (pc == 2);
                pc = (pc + 1) % 3;
            end
        endcase
    end

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [7:0] d;
        bit         s;   // checksum byte
    } ent_t;
    ent_t exp_q[$];

    bit         m_busy = 0, m_done = 0, m_rden = 0, m_valid = 0, m_cap = 0;
    logic [7:0] m_cur = 8'h00;
    bit         chk_on = 0;
    int         cyc = 0;

    // logs for literal checks
    int         rden_cyc[$];
    logic [7:0] addr_log[$];
    logic [7:0] byte_log[$];
    bit         last_log[$];
    int         hs_cyc[$];
    int         acc_cyc  = 0;
    int         done_cyc = 0;
    int         done_cnt = 0;

    task automatic clear_logs();
        rden_cyc.delete(); addr_log.delete(); byte_log.delete();
        last_log.delete(); hs_cyc.delete();
    endtask

    always @(negedge clk) begin
        bit         n_rden, n_done, n_valid, n_busy, n_cap, hs;
        logic [7:0] n_cur;
        ent_t       e;
        cyc++;
        if (rst) begin
            exp_q.delete();
            m_busy = 0; m_done = 0; m_rden = 0; m_valid = 0; m_cap = 0;
            m_cur = 8'h00;
            chk_on = 1;
        end else if (chk_on) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("rden", rden, m_rden);
            if (m_rden) chk("addr", addr, m_cur);
            chk("out_valid", out_valid, m_valid);
            if (m_valid && exp_q.size() > 0) begin
                chk("out_data", out_data, exp_q[0].d);
                chk("out_last", out_last, exp_q.size() == 1);
            end
            if (rden) begin rden_cyc.push_back(cyc); addr_log.push_back(addr); end
            if (out_valid && out_ready) begin
                byte_log.push_back(out_data);
                last_log.push_back(out_last);
                hs_cyc.push_back(cyc);
            end
            if (done) begin done_cnt++; done_cyc = cyc; end

            // advance the model across the next rising edge
            n_rden = 0; n_done = 0; n_valid = m_valid; n_busy = m_busy;
            n_cap = m_rden;
            n_cur = m_rden ? m_cur + 8'd1 : m_cur;
            if (m_cap) n_valid = 1;
            hs = m_valid && out_ready;
            if (hs && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (exp_q.size() == 0) begin
                    n_valid = 0; n_done = 1; n_busy = 0;
                end else if (exp_q[0].s) begin
                    n_valid = 1;
                end else begin
                    n_valid = 0; n_rden = 1;
                end
            end
            if (!m_busy && start) begin
                int         n;
                logic [7:0] sum;
                logic [7:0] a;
                n = (len == 8'h00) ? 256 : int'(len);
                sum = 8'h00;
                for (int i = 0; i < n; i++) begin
                    a = base + 8'(i);
                    e.d = a ^ 8'h5A; e.s = 0;
                    exp_q.push_back(e);
                    sum = sum + e.d;
                end
`ifdef DUMP_CHECKSUM_EN
                e.d = sum; e.s = 1;
                exp_q.push_back(e);
`endif
                n_busy = 1; n_rden = 1; n_cur = base;
                acc_cyc = cyc;
            end
            m_busy = n_busy; m_done = n_done; m_rden = n_rden;
            m_valid = n_valid; m_cap = n_cap; m_cur = n_cur;
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_start(input logic [7:0] b, input logic [7:0] l);
        clear_logs();
        base = b; len = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        base = 8'($urandom); len = 8'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int c0 = done_cnt;
        int k  = 0;
        while (done_cnt == c0 && k < budget) begin
            @(posedge clk); k++;
        end
        #1;
        if (done_cnt == c0) chk("done_timeout", 0, 1);
    endtask

    // compare captured stream against a directly computed list
    task automatic check_stream(input logic [7:0] b, input int n);
        logic [7:0] a;
        logic [7:0] sum = 8'h00;
        int tot = n;
`ifdef DUMP_CHECKSUM_EN
        tot = n + 1;
`endif
        chk("stream_len", byte_log.size(), tot);
        chk("rden_count", rden_cyc.size(), n);
        if (byte_log.size() == tot) begin
            for (int i = 0; i < n; i++) begin
                a = b + 8'(i);
                sum = sum + (a ^ 8'h5A);
                if (byte_log[i] !== (a ^ 8'h5A)) chk("stream_byte", byte_log[i], a ^ 8'h5A);
                if (last_log[i] !== (i == tot - 1)) chk("stream_last", last_log[i], i == tot - 1);
            end
`ifdef DUMP_CHECKSUM_EN
            chk("stream_sum", byte_log[n], sum);
            chk("stream_sum_last", last_log[n], 1);
`endif
            chk("done_after_hs", done_cyc, hs_cyc[tot - 1] + 1);
        end
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] l;
        rst = 1'b1; start = 1'b0; base = 8'h00; len = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
        chk("rst_addr", addr, 8'h00);  chk("rst_rden", rden, 0);
        chk("rst_data", out_data, 8'h00); chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // base=10, len=4, ready high; stray start while busy
        rmode = 0;
        do_start(8'h10, 8'd4);
        base = 8'h80; len = 8'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200);
        check_stream(8'h10, 4);
        if (byte_log.size() >= 4) begin
            chk("t1_b0", byte_log[0], 8'h4A); chk("t1_b1", byte_log[1], 8'h4B);
            chk("t1_b2", byte_log[2], 8'h48); chk("t1_b3", byte_log[3], 8'h49);
`ifdef DUMP_CHECKSUM_EN
            if (byte_log.size() >= 5) chk("t1_sum", byte_log[4], 8'h26);
`else
            chk("t1_last", last_log[3], 1);
`endif
        end
        if (rden_cyc.size() == 4)
            for (int i = 0; i < 4; i++) chk("t1_rden_cyc", rden_cyc[i] - acc_cyc, 1 + 3 * i);

        // wrap FE, FF, 00
        do_start(8'hFE, 8'd3);
        wait_done(200);
        check_stream(8'hFE, 3);
        if (addr_log.size() == 3) begin
            chk("wrap_a0", addr_log[0], 8'hFE); chk("wrap_a1", addr_log[1], 8'hFF);
            chk("wrap_a2", addr_log[2], 8'h00);
        end
        if (byte_log.size() >= 3) begin
            chk("wrap_b0", byte_log[0], 8'hA4); chk("wrap_b1", byte_log[1], 8'hA5);
            chk("wrap_b2", byte_log[2], 8'h5A);
        end

        // full 256-byte dump
        do_start(8'h00, 8'h00);
        wait_done(2000);
        check_stream(8'h00, 256);

        // stall pattern 0,0,1
        rmode = 2;
        do_start(8'h33, 8'd6);
        wait_done(400);
        check_stream(8'h33, 6);

        // reset during second SEND of a len=4 dump
        rmode = 0;
        @(posedge clk); #1;
        do_start(8'h20, 8'd4);   // now in cycle 1
        repeat (5) @(posedge clk);
        #1;                      // cycle 6: second SEND
        chk("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);   chk("mid_rst_done", done, 0);
        chk("mid_rst_addr", addr, 8'h00); chk("mid_rst_rden", rden, 0);
        chk("mid_rst_data", out_data, 8'h00); chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_last", out_last, 0);
        @(posedge clk); #1;
        chk("post_rst_done", done, 0);
        do_start(8'h10, 8'd4);
        wait_done(200);
        check_stream(8'h10, 4);

        // random dumps, random backpressure
        rmode = 1;
        for (int t = 0; t < 20; t++) begin
            b = 8'($urandom);
            l = 8'($urandom_range(1, 20));
            do_start(b, l);
            wait_done(2000);
            check_stream(b, int'(l));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
